// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command frame with CRC7 and captures
// the card response (48 or 136 bits) into four response words for the regbank.
module sd_cmd_engine #(
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_en,
    input  logic        start,
    input  logic [15:0] cmd_in,
    input  logic [31:0] arg_in,
    output logic        cmd_o,
    output logic        cmd_oe,
    input  logic        cmd_i,
    output logic [31:0] resp0_out,
    output logic [31:0] resp1_out,
    output logic [31:0] resp2_out,
    output logic [31:0] resp3_out,
    output logic        resp_we,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        crc_err,
    output logic        end_bit_err,
    output logic        index_err
);
    localparam int unsigned TO_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_CHECK} state_t;
    state_t r_state, w_next;

    logic [47:0]     r_frame;
    logic [7:0]      r_bitcnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [5:0]      r_index;
    logic            r_idx_chk, r_crc_chk, r_wr;
    logic [1:0]      r_rtype;
    logic [135:0]    r_rx;
    logic [31:0]     r_resp0, r_resp1, r_resp2, r_resp3;
    logic            r_timeout_err, r_crc_err, r_end_bit_err, r_index_err;

    logic [39:0]  w_hdr;
    logic [135:0] w_rx_next;
    logic [7:0]   w_rx_len;
    logic         w_tx_last, w_rx_last, w_timeout;
    logic         w_unused_bits;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = d[39 - i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign w_hdr         = {2'b01, cmd_in[13:8], arg_in};
    assign w_rx_next     = {r_rx[134:0], cmd_i};
    assign w_rx_len      = (r_rtype == 2'b01) ? 8'd136 : 8'd48;
    assign w_tx_last     = bit_en && (r_bitcnt == 8'd47);
    assign w_rx_last     = bit_en && ((r_bitcnt + 8'd1) == w_rx_len);
    assign w_timeout     = bit_en && cmd_i && (r_to_cnt == TO_W'(RESP_TIMEOUT - 1));
    assign w_unused_bits = ^{cmd_in[15:14], cmd_in[7:5], cmd_in[2], r_rx[135]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_TX;
            S_TX:    if (w_tx_last) w_next = (r_rtype == 2'b00) ? S_CHECK : S_WAIT;
            S_WAIT:  if (bit_en && !cmd_i) w_next = S_RX;
                     else if (w_timeout) w_next = S_CHECK;
            S_RX:    if (w_rx_last) w_next = S_CHECK;
            S_CHECK: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_oe  = 1'b0;
        cmd_o   = 1'b1;
        busy    = 1'b1;
        done    = 1'b0;
        resp_we = 1'b0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_TX:    begin cmd_oe = 1'b1; cmd_o = r_frame[47]; end
            S_CHECK: begin done = 1'b1; resp_we = r_wr; end
            default: ;
        endcase
    end

    // Response words and error flags are registered on the final RX strobe so
    // they are already valid in the CHECK cycle alongside resp_we/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= '0; r_bitcnt <= '0; r_to_cnt <= '0; r_index <= '0;
            r_idx_chk <= 1'b0; r_crc_chk <= 1'b0; r_wr <= 1'b0; r_rtype <= '0;
            r_rx <= '0;
            r_resp0 <= '0; r_resp1 <= '0; r_resp2 <= '0; r_resp3 <= '0;
            r_timeout_err <= 1'b0; r_crc_err <= 1'b0;
            r_end_bit_err <= 1'b0; r_index_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_frame       <= {w_hdr, crc7(w_hdr), 1'b1};
                    r_index       <= cmd_in[13:8];
                    r_idx_chk     <= cmd_in[4];
                    r_crc_chk     <= cmd_in[3];
                    r_rtype       <= cmd_in[1:0];
                    r_bitcnt      <= '0;
                    r_to_cnt      <= '0;
                    r_wr          <= 1'b0;
                    r_timeout_err <= 1'b0;
                    r_crc_err     <= 1'b0;
                    r_end_bit_err <= 1'b0;
                    r_index_err   <= 1'b0;
                end
                S_TX: if (bit_en) begin
                    r_frame  <= {r_frame[46:0], 1'b1};
                    r_bitcnt <= r_bitcnt + 8'd1;
                end
                S_WAIT: if (bit_en) begin
                    if (!cmd_i) begin
                        r_rx     <= '0;
                        r_bitcnt <= 8'd1;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_RX: if (bit_en) begin
                    r_rx     <= w_rx_next;
                    r_bitcnt <= r_bitcnt + 8'd1;
                    if (w_rx_last) begin
                        r_wr          <= 1'b1;
                        r_end_bit_err <= !w_rx_next[0];
                        if (r_rtype == 2'b01) begin
                            r_resp0 <= w_rx_next[39:8];
                            r_resp1 <= w_rx_next[71:40];
                            r_resp2 <= w_rx_next[103:72];
                            r_resp3 <= {8'h00, w_rx_next[127:104]};
                        end else begin
                            r_resp0     <= w_rx_next[39:8];
                            r_resp1     <= '0;
                            r_resp2     <= '0;
                            r_resp3     <= '0;
                            r_crc_err   <= r_crc_chk && (crc7(w_rx_next[47:8]) != w_rx_next[7:1]);
                            r_index_err <= r_idx_chk && (w_rx_next[45:40] != r_index);
                        end
                    end
                end
                S_CHECK: r_wr <= 1'b0;
                default: ;
            endcase
        end
    end

    assign resp0_out   = r_resp0;
    assign resp1_out   = r_resp1;
    assign resp2_out   = r_resp2;
    assign resp3_out   = r_resp3;
    assign timeout_err = r_timeout_err;
    assign crc_err     = r_crc_err;
    assign end_bit_err = r_end_bit_err;
    assign index_err   = r_index_err;
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: directed commands with hand-computed frames
// and responses; monitors compare TX frames and completion results from queues.
module tb_sd_cmd_engine;
    logic        clk, reset, bit_en, start, cmd_i;
    logic [15:0] cmd_in;
    logic [31:0] arg_in;
    logic        cmd_o, cmd_oe, resp_we, busy, done;
    logic [31:0] resp0_out, resp1_out, resp2_out, resp3_out;
    logic        timeout_err, crc_err, end_bit_err, index_err;

    typedef struct {
        logic        we;
        logic [31:0] r0, r1, r2, r3;
        logic [3:0]  err;
    } exp_t;

    exp_t        sb_q[$];
    logic [47:0] frm_q[$];
    int          checks = 0;
    int          failures = 0;

    sd_cmd_engine #(.RESP_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .bit_en(bit_en), .start(start),
        .cmd_in(cmd_in), .arg_in(arg_in), .cmd_o(cmd_o), .cmd_oe(cmd_oe),
        .cmd_i(cmd_i), .resp0_out(resp0_out), .resp1_out(resp1_out),
        .resp2_out(resp2_out), .resp3_out(resp3_out), .resp_we(resp_we),
        .busy(busy), .done(done), .timeout_err(timeout_err), .crc_err(crc_err),
        .end_bit_err(end_bit_err), .index_err(index_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int k;
        k = 0;
        bit_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            k = (k + 1) % 4;
            bit_en = (k == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Frame monitor: collects 48 driven bits, one per strobe while cmd_oe is high.
    initial begin
        logic [47:0] cap;
        int          cnt;
        cnt = 0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0;
            end else if (cmd_oe && bit_en) begin
                cap = {cap[46:0], cmd_o};
                cnt++;
                if (cnt == 48) begin
                    cnt = 0;
                    if (frm_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL frame_unexpected actual=0x%0h required=none", cap);
                    end else begin
                        check("tx_frame", cap, frm_q.pop_front());
                    end
                end
            end
        end
    end

    // Completion monitor: every done pulse is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    e = sb_q.pop_front();
                    check("resp_we", resp_we, e.we);
                    check("resp_words", {resp3_out, resp2_out, resp1_out, resp0_out},
                          {e.r3, e.r2, e.r1, e.r0});
                    check("err_flags", {timeout_err, crc_err, end_bit_err, index_err}, e.err);
                end
            end else if (!reset && resp_we) begin
                checks++; failures++;
                $display("FAIL resp_we_without_done actual=1 required=0");
            end
        end
    end

    task automatic expect_done(input logic we, input logic [31:0] r3, input logic [31:0] r2,
                               input logic [31:0] r1, input logic [31:0] r0, input logic [3:0] err);
        exp_t e;
        e.we = we; e.r0 = r0; e.r1 = r1; e.r2 = r2; e.r3 = r3; e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [15:0] c, input logic [31:0] a, input bit on_strobe);
        if (on_strobe) begin
            do @(negedge clk); while (!bit_en);
        end else begin
            @(negedge clk);
        end
        cmd_in = c;
        arg_in = a;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cmd_in = 16'hFFFF;
        arg_in = 32'hDEADBEEF;
        check("busy_after_start", busy, 1'b1);
        check("oe_after_start", cmd_oe, 1'b1);
        check("err_cleared", {timeout_err, crc_err, end_bit_err, index_err}, 4'b0000);
    endtask

    task automatic wait_tx_end();
        int n;
        n = 0;
        while (cmd_oe && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_end_seen", cmd_oe, 1'b0);
    endtask

    task automatic strobe_drive(input logic v);
        do @(negedge clk); while (!bit_en);
        cmd_i = v;
    endtask

    task automatic send_resp(input logic [135:0] r, input int len, input int nbits);
        strobe_drive(1'b1);
        strobe_drive(1'b1);
        for (int i = 0; i < nbits; i++) strobe_drive(r[len - 1 - i]);
        @(posedge clk);
        @(negedge clk);
        cmd_i = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
        @(negedge clk);
    endtask

    task automatic run_cmd8_resp(input logic [15:0] c, input logic [47:0] r);
        frm_q.push_back(48'h48000001AA87);
        issue(c, 32'h000001AA, 1'b0);
        wait_tx_end();
        send_resp({88'h0, r}, 48, 48);
        wait_done(100);
    endtask

    initial begin
        int cnt, n;
        reset = 1'b1; start = 1'b0; cmd_i = 1'b1;
        cmd_in = '0; arg_in = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_o", cmd_o, 1'b1);
        check("rst_cmd_oe", cmd_oe, 1'b0);
        check("rst_busy_done_we", {busy, done, resp_we}, 3'b000);
        check("rst_errs", {timeout_err, crc_err, end_bit_err, index_err}, 4'b0000);
        check("rst_resp", {resp3_out, resp2_out, resp1_out, resp0_out}, 128'h0);
        reset = 1'b0;
        @(negedge clk);

        // CMD0: start coincides with a strobe; done the cycle after the last bit
        frm_q.push_back(48'h400000000095);
        expect_done(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
        issue(16'h0000, 32'h0, 1'b1);
        wait_tx_end();
        check("cmd0_done_latency", done, 1'b1);
        @(negedge clk);

        // CMD8 good response, with an ignored start while busy
        frm_q.push_back(48'h48000001AA87);
        expect_done(1'b1, 32'h0, 32'h0, 32'h0, 32'h000001AA, 4'b0000);
        issue(16'h081A, 32'h000001AA, 1'b0);
        repeat (10) @(negedge clk);
        cmd_in = 16'h0000; arg_in = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_tx_end();
        send_resp({88'h0, 48'h08000001AA13}, 48, 48);
        wait_done(100);

        // Timeout: no card response
        frm_q.push_back(48'h48000001AA87);
        expect_done(1'b0, 32'h0, 32'h0, 32'h0, 32'h000001AA, 4'b1000);
        issue(16'h081A, 32'h000001AA, 1'b0);
        wait_tx_end();
        cnt = 0; n = 0;
        while (!done && n < 1000) begin
            if (bit_en) cnt++;
            @(negedge clk);
            n++;
        end
        check("timeout_strobes", cnt, 64);
        @(negedge clk);

        // Bad CRC, wrong index (CRC check off), bad end bit
        expect_done(1'b1, 32'h0, 32'h0, 32'h0, 32'h000001AA, 4'b0100);
        run_cmd8_resp(16'h081A, 48'h08000001AA11);
        expect_done(1'b1, 32'h0, 32'h0, 32'h0, 32'h000001AA, 4'b0001);
        run_cmd8_resp(16'h0812, 48'h09000001AA13);
        expect_done(1'b1, 32'h0, 32'h0, 32'h0, 32'h000001AA, 4'b0010);
        run_cmd8_resp(16'h081A, 48'h08000001AA12);

        // CMD2: 136-bit response
        frm_q.push_back(48'h42000000004D);
        expect_done(1'b1, 32'h00012345, 32'h6789ABCD, 32'hEFFEDCBA, 32'h98765432, 4'b0000);
        issue(16'h0209, 32'h0, 1'b0);
        wait_tx_end();
        send_resp({8'h3F, 120'h0123456789ABCDEFFEDCBA98765432, 8'h01}, 136, 136);
        wait_done(100);

        // Reset mid-TX
        issue(16'h081A, 32'h000001AA, 1'b0);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midtx_rst_oe_busy", {cmd_oe, busy}, 2'b00);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-RX
        frm_q.push_back(48'h48000001AA87);
        issue(16'h081A, 32'h000001AA, 1'b0);
        wait_tx_end();
        send_resp({88'h0, 48'h08000001AA13}, 48, 20);
        reset = 1'b1;
        @(negedge clk);
        check("midrx_rst_oe_busy", {cmd_oe, busy, resp_we}, 3'b000);
        check("midrx_rst_resp0", resp0_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cmd_i = 1'b1;

        // CMD0 after aborts completes normally
        frm_q.push_back(48'h400000000095);
        expect_done(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
        issue(16'h0000, 32'h0, 1'b0);
        wait_tx_end();
        wait_done(10);

        repeat (10) @(negedge clk);
        check("sb_queue_empty", sb_q.size(), 0);
        check("frame_queue_empty", frm_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
